// File: rtl/rx_demodulator_pkg.sv
// Shared definitions for the RX demodulator and the TX/LO phase-shift path:
// lane geometry and acquisition FSM state encoding.
package rx_demodulator_pkg;

  localparam int N_PARA    = 4;
  localparam int N_BITS_IN = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rx_demodulator_demod_mac.sv
// Single-channel demodulator: capture, 4-lane multiply, lane sum, then
// accumulate-and-dump over one decimation block. Output lands 3 edges after the accepting edge.
module demod_mac
  import rx_demodulator_pkg::*;
#(
  parameter int N_BITS_OUT = 32,
  parameter int DEC_LOG2   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_PARA*N_BITS_IN-1:0]   samples,
  input  logic [N_PARA*N_BITS_IN-1:0]   lo,
  input  logic                          valid,
  input  logic                          dump,
  input  logic                          clear,
  output logic signed [N_BITS_OUT-1:0]  result,
  output logic                          result_valid
);

  localparam int PW = 2 * N_BITS_IN;
  localparam int SW = PW + $clog2(N_PARA);
  localparam int AW = SW + DEC_LOG2;

  logic [N_PARA*N_BITS_IN-1:0] s0_smp, s0_lo;
  logic                        s0_vld, s0_dump;
  logic signed [PW-1:0]        prod    [N_PARA];
  logic signed [PW-1:0]        s1_prod [N_PARA];
  logic                        s1_vld, s1_dump;
  logic signed [SW-1:0]        lane_sum, s2_sum;
  logic                        s2_vld, s2_dump;
  logic signed [AW-1:0]        acc, acc_next;

  always_comb begin
    for (int k = 0; k < N_PARA; k++) begin
      prod[k] = PW'($signed(s0_smp[k*N_BITS_IN +: N_BITS_IN])) *
                PW'($signed(s0_lo[k*N_BITS_IN +: N_BITS_IN]));
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < N_PARA; k++) begin
      lane_sum = lane_sum + SW'(s1_prod[k]);
    end
  end

  assign acc_next = acc + AW'(s2_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_smp       <= '0;
      s0_lo        <= '0;
      s0_vld       <= 1'b0;
      s0_dump      <= 1'b0;
      s1_prod      <= '{default: '0};
      s1_vld       <= 1'b0;
      s1_dump      <= 1'b0;
      s2_sum       <= '0;
      s2_vld       <= 1'b0;
      s2_dump      <= 1'b0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      s0_smp   <= samples;
      s0_lo    <= lo;
      s1_prod  <= prod;
      s2_sum   <= lane_sum;
      if (clear) begin
        s0_vld       <= 1'b0;
        s0_dump      <= 1'b0;
        s1_vld       <= 1'b0;
        s1_dump      <= 1'b0;
        s2_vld       <= 1'b0;
        s2_dump      <= 1'b0;
        acc          <= '0;
        result_valid <= 1'b0;
      end else begin
        s0_vld       <= valid;
        s0_dump      <= valid & dump;
        s1_vld       <= s0_vld;
        s1_dump      <= s0_dump;
        s2_vld       <= s1_vld;
        s2_dump      <= s1_dump;
        result_valid <= s2_vld & s2_dump;
        if (s2_vld) begin
          if (s2_dump) begin
            // Top bits of the block sum == floor(sum / (block_len * N_PARA)).
            result <= acc_next[AW-1 -: N_BITS_OUT];
            acc    <= '0;
          end else begin
            acc <= acc_next;
          end
        end
      end
    end
  end

endmodule

// File: rtl/rx_demodulator.sv
// Gated I/Q demodulator: acquires acq_len decimated baseband samples per start,
// then strobes done. Two demod_mac channels share the block/count FSM here.
module rx_demodulator
  import rx_demodulator_pkg::*;
#(
  parameter int N_BITS_OUT = 32,
  parameter int DEC_LOG2   = 4,
  parameter int LEN_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_PARA*N_BITS_IN-1:0]  adc_in,
  input  logic [N_PARA*N_BITS_IN-1:0]  lo_i,
  input  logic [N_PARA*N_BITS_IN-1:0]  lo_q,
  input  logic                         in_valid,
  input  logic                         start,
  input  logic                         abort,
  input  logic [LEN_W-1:0]             acq_len,
  output logic signed [N_BITS_OUT-1:0] I_out,
  output logic signed [N_BITS_OUT-1:0] Q_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         done
);

  state_t               state;
  logic [DEC_LOG2-1:0]  blk_cnt;
  logic [LEN_W-1:0]     blk_done;
  logic [LEN_W-1:0]     len_reg;
  logic                 accept, dump, last_blk, kill;
  logic                 i_vld, q_vld;

  assign accept   = (state == ST_ACQ) && in_valid;
  assign dump     = accept && (&blk_cnt);
  assign last_blk = dump && ((blk_done + LEN_W'(1)) == len_reg);
  assign kill     = abort && (state != ST_IDLE);
  assign out_valid = i_vld & q_vld;

  demod_mac #(.N_BITS_OUT(N_BITS_OUT), .DEC_LOG2(DEC_LOG2)) u_mac_i (
    .clk(clk), .rst_n(rst_n), .samples(adc_in), .lo(lo_i),
    .valid(accept), .dump(dump), .clear(kill),
    .result(I_out), .result_valid(i_vld)
  );

  demod_mac #(.N_BITS_OUT(N_BITS_OUT), .DEC_LOG2(DEC_LOG2)) u_mac_q (
    .clk(clk), .rst_n(rst_n), .samples(adc_in), .lo(lo_q),
    .valid(accept), .dump(dump), .clear(kill),
    .result(Q_out), .result_valid(q_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      blk_cnt  <= '0;
      blk_done <= '0;
      len_reg  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (kill) begin
      state    <= ST_IDLE;
      blk_cnt  <= '0;
      blk_done <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && (acq_len != '0)) begin
            state    <= ST_ACQ;
            len_reg  <= acq_len;
            blk_cnt  <= '0;
            blk_done <= '0;
            busy     <= 1'b1;
          end
        end
        ST_ACQ: begin
          if (accept) begin
            blk_cnt <= blk_cnt + 1'b1;
            if (dump) blk_done <= blk_done + LEN_W'(1);
            if (last_blk) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Earlier blocks have already left the pipe, so the next strobe is the last one.
          if (out_valid) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
